acc_fp: RTL and testbench
=========================

ACC_FP -- requirements
Module: acc_fp

Interface
REQ-001 Parameters SHALL be (name, default, meaning): NB_IN, 13, input word width; NB_OUT, 13, output word width; NB_M, 8, mantissa bits; NB_S, 1, sign bits; NB_E, 4, exponent bits; NB_ACC, 32, signed accumulator width.
REQ-002 The block SHALL use one clock; reset is synchronous and active-low.
REQ-003 Port: clock, input, 1, rising-edge clock.
REQ-004 Port: rst_n, input, 1, reset, active low, sampled on rising edge of clock.
REQ-005 Port: x, input, NB_IN, fp term {s, e, m} from upstream multiplier.
REQ-006 Port: x_valid, input, 1, x is valid this cycle.
REQ-007 Port: x_last, input, 1, x is final term of current sum; qualified by x_valid.
REQ-008 Port: x_ready, output, 1, block accepts x this cycle.
REQ-009 Port: y, output, NB_OUT, fp sum {s, e, m}.
REQ-010 Port: y_valid, output, 1, y is valid.
REQ-011 Port: y_ready, input, 1, downstream accepts y.

Function
REQ-012 Number format SHALL be value = (-1)^s * 1.m * 2^(e-7); e==0 SHALL mean zero, whatever m is.
REQ-013 Each accepted term SHALL be aligned as {1,m} << e (LSB weight 2^-15), or 0 when e==0, negated when s==1, then added to acc.
REQ-014 acc SHALL saturate at +(2^(NB_ACC-1)-1) and -(2^(NB_ACC-1)-1); it SHALL never wrap.
REQ-015 A transfer SHALL occur on a rising edge where x_valid && x_ready; x_ready SHALL be 1 only in state ACC.
REQ-016 FSM states SHALL be ACC, ABS, NORM, PACK, OUT.
REQ-017 Transitions: ACC->ABS on a transfer with x_last=1; ABS->NORM after 1 cycle; NORM->PACK when mag[NB_ACC-1]==1 or mag==0, otherwise shift mag left by 1 and stay; PACK->OUT after 1 cycle; OUT->ACC on y_valid && y_ready.
REQ-018 ABS SHALL latch sign = acc<0 and mag = |acc|.
REQ-019 Latency: with the x_last transfer on edge T, y_valid SHALL rise after edge T+3+lz; lz = leading zeros of |acc| in NB_ACC bits (lz=0 when |acc|==0).
REQ-020 PACK: with p = NB_ACC-1-lz, e_out SHALL be p-8 and m SHALL be the NB_M bits below the leading one.
REQ-021 Underflow: p<9 or mag==0 SHALL give y=0 (all bits zero).
REQ-022 Overflow: p>23 SHALL give y={sign, all-ones e, all-ones m}.
REQ-023 y and y_valid SHALL be registered and held stable in OUT until y_ready.
REQ-024 acc SHALL clear to 0 on the OUT->ACC transition.
REQ-025 x_valid/x/x_last SHALL be ignored outside ACC; the upstream holds them.

Reset
REQ-026 rst_n==0 at a rising edge SHALL force: state ACC, acc=0, mag=0, y=0, y_valid=0. x_ready SHALL be 1 from the next cycle.
REQ-027 Reset in any state SHALL abort the sum in progress with no y emitted.

Configuration
REQ-028 With ACC_FP_ROUND_EN defined, PACK SHALL round half-up on the guard bit (the bit below m).
REQ-029 Under ACC_FP_ROUND_EN, a mantissa carry SHALL set m=0 and e_out+1; if e_out+1 exceeds 15, the result SHALL saturate per REQ-022.
REQ-030 Without ACC_FP_ROUND_EN, PACK SHALL truncate m.

Verification
REQ-031 Pass-through: single term 13'b0111110111010 with x_last -> y=13'b0111110111010 after T+3+8 (lz=8).
REQ-032 Sum: 13'b0101011000000 (14), then 13'b1101100000000 (-16, last) -> y=13'b1100000000000 (-2), lz=15.
REQ-033 Saturation: 511 + 511 (13'b0111111111111 twice) -> y=13'b0111111111111; 14 + 0 (e=0 term) -> 13'b0101011000000.
REQ-034 Rounding: 256 (13'b0111100000000) + 0.5 (13'b0011000000000) -> y=13'b0111100000001 with ACC_FP_ROUND_EN; 13'b0111100000000 without.
REQ-035 Backpressure/reset: y_ready=0 for 5 cycles -> y, y_valid stable and x_ready=0; rst_n=0 in NORM -> y_valid never rises, next sum starts from acc=0.
REQ-036 Cancel/underflow: 14 + (-14) -> y=0, y_valid after T+3.

Source files
------------

// File: rtl/acc_fp.sv
// Floating-point term accumulator: sums {s,e,m} terms into a saturating fixed-point
// accumulator, then normalises and packs the sum back to {s,e,m}. Define ACC_FP_ROUND_EN for round-half-up packing.
module acc_fp #(
  parameter int NB_IN  = 13,
  parameter int NB_OUT = 13,
  parameter int NB_M   = 8,
  parameter int NB_S   = 1,
  parameter int NB_E   = 4,
  parameter int NB_ACC = 32
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic [NB_IN-1:0]  x,
  input  logic              x_valid,
  input  logic              x_last,
  output logic              x_ready,
  output logic [NB_OUT-1:0] y,
  output logic              y_valid,
  input  logic              y_ready
);

  localparam int LZW = $clog2(NB_ACC) + 1;
  localparam int EW  = 8;
  // Exponent of a normalised magnitude with zero leading zeros; each leading zero costs one.
  localparam logic signed [EW-1:0] E_TOP = EW'(NB_ACC - 1 - NB_M);
  localparam logic signed [EW-1:0] E_LIM = EW'((1 << NB_E) - 1);
  localparam logic signed [NB_ACC:0] SAT_P = $signed({2'b00, {(NB_ACC-1){1'b1}}});
  localparam logic signed [NB_ACC:0] SAT_N = -SAT_P;

  typedef enum logic [2:0] {
    S_ACC  = 3'd0,
    S_ABS  = 3'd1,
    S_NORM = 3'd2,
    S_PACK = 3'd3,
    S_OUT  = 3'd4
  } state_t;

  state_t              state_r;
  logic [NB_ACC-1:0]   acc_r;
  logic [NB_ACC-1:0]   mag_r;
  logic                sign_r;
  logic [LZW-1:0]      lz_r;
  logic [NB_OUT-1:0]   y_r;
  logic                y_valid_r;
  logic                x_ready_r;

  logic                x_s_s;
  logic [NB_E-1:0]     x_e_s;
  logic [NB_M-1:0]     x_m_s;
  logic [NB_ACC-1:0]   mag_in_s;
  logic signed [NB_ACC:0] term_s;
  logic signed [NB_ACC:0] sum_s;
  logic [NB_ACC-1:0]   acc_next_s;
  logic [NB_ACC-1:0]   abs_s;

  logic signed [EW-1:0] e_raw_s;
  logic signed [EW-1:0] e_s;
  logic [NB_M-1:0]     m_s;
  logic [NB_OUT-1:0]   pack_s;

  assign x_ready = x_ready_r;
  assign y       = y_r;
  assign y_valid = y_valid_r;

  // Align the incoming term and add it to the accumulator with symmetric saturation.
  always_comb begin
    x_s_s    = x[NB_IN-1];
    x_e_s    = x[NB_M +: NB_E];
    x_m_s    = x[NB_M-1:0];
    mag_in_s = {{(NB_ACC-NB_M-1){1'b0}}, 1'b1, x_m_s} << x_e_s;
    term_s   = '0;
    if (x_e_s == '0) begin
      term_s = '0;
    end else if (x_s_s) begin
      term_s = -$signed({1'b0, mag_in_s});
    end else begin
      term_s = $signed({1'b0, mag_in_s});
    end
    sum_s = $signed({acc_r[NB_ACC-1], acc_r}) + term_s;
    if (sum_s > SAT_P) begin
      acc_next_s = SAT_P[NB_ACC-1:0];
    end else if (sum_s < SAT_N) begin
      acc_next_s = SAT_N[NB_ACC-1:0];
    end else begin
      acc_next_s = sum_s[NB_ACC-1:0];
    end
    abs_s = acc_r[NB_ACC-1] ? (~acc_r + {{(NB_ACC-1){1'b0}}, 1'b1}) : acc_r;
  end

  // Pack the normalised magnitude into {s,e,m}, handling underflow, overflow and rounding.
  always_comb begin
    e_raw_s = E_TOP - $signed({{(EW-LZW){1'b0}}, lz_r});
    e_s     = e_raw_s;
    m_s     = mag_r[NB_ACC-2 -: NB_M];
`ifdef ACC_FP_ROUND_EN
    if (mag_r[NB_ACC-2-NB_M]) begin
      if (&m_s) begin
        m_s = '0;
        e_s = e_raw_s + 8'sd1;
      end else begin
        m_s = m_s + {{(NB_M-1){1'b0}}, 1'b1};
      end
    end else begin
      m_s = mag_r[NB_ACC-2 -: NB_M];
    end
`else
    m_s = mag_r[NB_ACC-2 -: NB_M];
`endif
    if ((mag_r == '0) || (e_raw_s < 8'sd1)) begin
      pack_s = '0;
    end else if (e_s > E_LIM) begin
      pack_s = {sign_r, {NB_E{1'b1}}, {NB_M{1'b1}}};
    end else begin
      pack_s = {sign_r, e_s[NB_E-1:0], m_s};
    end
  end

  // Control FSM with all datapath registers and registered handshake outputs.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_r   <= S_ACC;
      acc_r     <= '0;
      mag_r     <= '0;
      sign_r    <= 1'b0;
      lz_r      <= '0;
      y_r       <= '0;
      y_valid_r <= 1'b0;
      x_ready_r <= 1'b1;
    end else begin
      case (state_r)
        S_ACC: begin
          if (x_valid && x_ready_r) begin
            acc_r <= acc_next_s;
            if (x_last) begin
              state_r   <= S_ABS;
              x_ready_r <= 1'b0;
            end
          end
        end
        S_ABS: begin
          sign_r  <= acc_r[NB_ACC-1];
          mag_r   <= abs_s;
          lz_r    <= '0;
          state_r <= S_NORM;
        end
        S_NORM: begin
          if (mag_r[NB_ACC-1] || (mag_r == '0)) begin
            state_r <= S_PACK;
          end else begin
            mag_r <= {mag_r[NB_ACC-2:0], 1'b0};
            lz_r  <= lz_r + {{(LZW-1){1'b0}}, 1'b1};
          end
        end
        S_PACK: begin
          y_r       <= pack_s;
          y_valid_r <= 1'b1;
          state_r   <= S_OUT;
        end
        S_OUT: begin
          if (y_ready) begin
            y_valid_r <= 1'b0;
            acc_r     <= '0;
            x_ready_r <= 1'b1;
            state_r   <= S_ACC;
          end
        end
        default: begin
          state_r   <= S_ACC;
          acc_r     <= '0;
          y_valid_r <= 1'b0;
          x_ready_r <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_acc_fp.sv
// Directed self-checking bench for acc_fp: pass-through, sums, saturation,
// rounding, backpressure, reset abort, cancellation and underflow boundaries.
`timescale 1ns/1ps
module tb_acc_fp;

  logic        clock;
  logic        rst_n;
  logic [12:0] x;
  logic        x_valid;
  logic        x_last;
  logic        x_ready;
  logic [12:0] y;
  logic        y_valid;
  logic        y_ready;

  int checks;
  int fails;

  acc_fp dut (
    .clock   (clock),
    .rst_n   (rst_n),
    .x       (x),
    .x_valid (x_valid),
    .x_last  (x_last),
    .x_ready (x_ready),
    .y       (y),
    .y_valid (y_valid),
    .y_ready (y_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Present one term for exactly one rising edge; returns 1ns after that edge.
  task automatic send(input logic [12:0] v, input logic last);
    checks++;
    if (x_ready !== 1'b1) begin
      fails++;
      $display("FAIL send_ready: x_ready=%b required 1", x_ready);
    end
    x = v; x_valid = 1'b1; x_last = last;
    @(posedge clock); #1;
    x_valid = 1'b0; x_last = 1'b0;
  endtask

  // Called 1ns after the x_last edge: checks latency and value, then accepts y.
  task automatic wait_y(input int exp_lat, input logic [12:0] exp_y, input string name);
    int n;
    n = 0;
    while (y_valid !== 1'b1 && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    checks++;
    if (n !== exp_lat) begin
      fails++;
      $display("FAIL %s_latency: got %0d required %0d", name, n, exp_lat);
    end
    checks++;
    if (y !== exp_y) begin
      fails++;
      $display("FAIL %s_value: got %b required %b", name, y, exp_y);
    end
    y_ready = 1'b1;
    @(posedge clock); #1;
    y_ready = 1'b0;
    checks++;
    if (y_valid !== 1'b0 || x_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s_release: y_valid=%b x_ready=%b required 0 1", name, y_valid, x_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (x_ready !== 1'b1 || y_valid !== 1'b0 || y !== 13'b0) begin
      fails++;
      $display("FAIL reset: x_ready=%b y_valid=%b y=%b required 1 0 0", x_ready, y_valid, y);
    end
    rst_n = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_pass_through();
    send(13'b0111110111010, 1'b1);
    wait_y(11, 13'b0111110111010, "pass_through");
  endtask

  task automatic test_sum();
    send(13'b0101011000000, 1'b0);
    send(13'b1101100000000, 1'b1);
    wait_y(18, 13'b1100000000000, "sum_neg");
  endtask

  task automatic test_saturation();
    send(13'b0111111111111, 1'b0);
    send(13'b0111111111111, 1'b1);
    wait_y(10, 13'b0111111111111, "overflow");
    send(13'b0101011000000, 1'b0);
    send(13'b0000010101010, 1'b1);
    wait_y(16, 13'b0101011000000, "zero_term");
  endtask

  task automatic test_rounding();
    send(13'b0111100000000, 1'b0);
    send(13'b0011000000000, 1'b1);
`ifdef ACC_FP_ROUND_EN
    wait_y(11, 13'b0111100000001, "round_half");
`else
    wait_y(11, 13'b0111100000000, "truncate");
`endif
    // All-ones mantissa with guard set: carry or truncation both end at the top code.
    send(13'b0111111111111, 1'b0);
    send(13'b0011000000000, 1'b1);
    wait_y(11, 13'b0111111111111, "round_carry");
  endtask

  task automatic test_backpressure();
    int n;
    send(13'b0111110111010, 1'b1);
    n = 0;
    while (y_valid !== 1'b1 && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    checks++;
    if (n !== 11) begin
      fails++;
      $display("FAIL bp_latency: got %0d required 11", n);
    end
    x = 13'b0111111111111; x_valid = 1'b1; x_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      checks++;
      if (y !== 13'b0111110111010 || y_valid !== 1'b1 || x_ready !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold%0d: y=%b y_valid=%b x_ready=%b required 0111110111010 1 0",
                 i, y, y_valid, x_ready);
      end
    end
    x_valid = 1'b0; x_last = 1'b0;
    y_ready = 1'b1;
    @(posedge clock); #1;
    y_ready = 1'b0;
    checks++;
    if (y_valid !== 1'b0 || x_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_release: y_valid=%b x_ready=%b required 0 1", y_valid, x_ready);
    end
    // Accumulator must have been cleared on the handshake.
    send(13'b0101011000000, 1'b1);
    wait_y(16, 13'b0101011000000, "after_bp");
  endtask

  task automatic test_reset_in_norm();
    int seen;
    send(13'b0111111111111, 1'b0);
    send(13'b0101011000000, 1'b1);
    @(posedge clock); #1;
    @(posedge clock); #1;
    rst_n = 1'b0;
    @(posedge clock); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (y_valid === 1'b1) seen++;
      @(posedge clock); #1;
    end
    checks++;
    if (seen !== 0 || x_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_abort: y_valid cycles=%0d x_ready=%b required 0 1", seen, x_ready);
    end
    send(13'b0101011000000, 1'b1);
    wait_y(16, 13'b0101011000000, "after_reset");
  endtask

  task automatic test_cancel_underflow();
    send(13'b0101011000000, 1'b0);
    send(13'b1101011000000, 1'b1);
    wait_y(3, 13'b0, "cancel");
    send(13'b0000100000000, 1'b1);
    wait_y(25, 13'b0000100000000, "min_normal");
    send(13'b0000100000001, 1'b0);
    send(13'b1000100000000, 1'b1);
    wait_y(33, 13'b0, "underflow");
  endtask

  task automatic test_back_to_back();
    send(13'b0101011000000, 1'b1);
    wait_y(16, 13'b0101011000000, "b2b_first");
    send(13'b1101100000000, 1'b1);
    wait_y(15, 13'b1101100000000, "b2b_second");
  endtask

  initial begin
    checks = 0; fails = 0;
    rst_n = 1'b0; x = 13'b0; x_valid = 1'b0; x_last = 1'b0; y_ready = 1'b0;
    test_reset();
    test_pass_through();
    test_sum();
    test_saturation();
    test_rounding();
    test_backpressure();
    test_reset_in_norm();
    test_cancel_underflow();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
